// File: rtl/s2_deserializer.sv
// Serial frame receiver: reassembles address/payload frames from sen/sd and
// issues one single-cycle RB2 write per complete frame, then flags done.
module s2_deserializer #(
  parameter int ADDR_BITS = 3,
  parameter int DATA_BITS = 18,
  parameter int N_FRAMES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sen,
  input  logic                 sd,
  output logic                 RB2_RW,
  output logic [ADDR_BITS-1:0] RB2_A,
  output logic [DATA_BITS-1:0] RB2_D,
  input  logic [DATA_BITS-1:0] RB2_Q,
  output logic                 S2_done
);

  localparam int unsigned TOTAL = ADDR_BITS + DATA_BITS;
  localparam int unsigned BW    = $clog2(TOTAL + 1);
  localparam int unsigned FW    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam logic [BW-1:0] A_C    = BW'(ADDR_BITS);
  localparam logic [BW-1:0] T_C    = BW'(TOTAL);
  localparam logic [FW-1:0] LAST_F = FW'(N_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, FULL, DONE} state_t;

  state_t                 state, next;
  logic [BW-1:0]          bcnt;
  logic [FW-1:0]          fcnt;
  logic [ADDR_BITS-1:0]   a_sh, a_hold;
  logic [DATA_BITS-1:0]   d_sh, d_hold;
  logic                   wr_pend;
  logic                   active, shift_a, shift_d, close, strobe_last;
  logic                   unused_q;

  assign unused_q = ^RB2_Q;
  assign S2_done  = (state == DONE);

  always_comb begin
    next        = state;
    active      = (state != DONE);
    shift_a     = active && !sen && (bcnt < A_C);
    shift_d     = active && !sen && (bcnt >= A_C) && (bcnt < T_C);
    close       = active && sen && (bcnt == T_C);
    strobe_last = active && !RB2_RW && (fcnt == LAST_F);
    if (strobe_last) begin
      next = DONE;
    end else begin
      case (state)
        IDLE: if (!sen) next = ADDR;
        ADDR: if (sen) next = IDLE;
              else if (bcnt == A_C - BW'(1)) next = DATA;
        DATA: if (sen) next = IDLE;
              else if (bcnt == T_C - BW'(1)) next = FULL;
        FULL: if (sen) next = IDLE;
        default: next = state;
      endcase
    end
  end

  // Shift registers feed separate holding registers, so a frame starting in
  // the strobe cycle never disturbs the word being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      fcnt    <= '0;
      a_sh    <= '0;
      d_sh    <= '0;
      a_hold  <= '0;
      d_hold  <= '0;
      wr_pend <= 1'b0;
      RB2_RW  <= 1'b1;
      RB2_A   <= '0;
      RB2_D   <= '0;
    end else begin
      state   <= next;
      RB2_RW  <= ~wr_pend;
      wr_pend <= 1'b0;
      if (wr_pend) begin
        RB2_A <= a_hold;
        RB2_D <= d_hold;
      end
      if (!RB2_RW) fcnt <= fcnt + FW'(1);
      if (shift_a) begin
        a_sh <= (a_sh << 1) | ADDR_BITS'(sd);
        bcnt <= bcnt + BW'(1);
      end
      if (shift_d) begin
        d_sh <= (d_sh << 1) | DATA_BITS'(sd);
        bcnt <= bcnt + BW'(1);
      end
      if (sen) begin
        bcnt <= '0;
        if (close) begin
          a_hold  <= a_sh;
          d_hold  <= d_sh;
          wr_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_s2_deserializer.sv
// Bench for s2_deserializer: directed scenarios plus random frames, all
// outputs compared every cycle against a bit-queue reference model.
module tb_s2_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sen = 1'b1;
  logic        sd  = 1'b0;
  logic        RB2_RW;
  logic [2:0]  RB2_A;
  logic [17:0] RB2_D;
  logic [17:0] RB2_Q = '0;
  logic        S2_done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  int strobes = 0;

  s2_deserializer #(.ADDR_BITS(3), .DATA_BITS(18), .N_FRAMES(8)) dut (
    .clk(clk), .rst(rst), .sen(sen), .sd(sd), .RB2_RW(RB2_RW),
    .RB2_A(RB2_A), .RB2_D(RB2_D), .RB2_Q(RB2_Q), .S2_done(S2_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: collect frame bits in a queue, decode on close.
  bit m_rw = 1, m_done = 0, pend = 0;
  int m_a = 0, m_d = 0, nfr = 0, pa = 0, pd = 0;
  int bits[$];

  always @(posedge clk) begin
    if (rst) begin
      m_rw = 1; m_done = 0; pend = 0; m_a = 0; m_d = 0; nfr = 0;
      bits.delete();
    end else begin
      if (!m_rw) begin
        nfr++;
        if (nfr == 8) m_done = 1;
        m_rw = 1;
      end
      if (pend) begin
        m_rw = 0; m_a = pa; m_d = pd; pend = 0;
      end
      if (!m_done) begin
        if (!sen) begin
          if (bits.size() < 21) bits.push_back(int'(sd));
        end else begin
          if (bits.size() == 21) begin
            pa = 0; pd = 0;
            for (int i = 0; i < 3; i++) pa = pa * 2 + bits[i];
            for (int i = 3; i < 21; i++) pd = pd * 2 + bits[i];
            pend = 1;
          end
          bits.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rw",   32'(RB2_RW),  32'(m_rw));
      check("addr", 32'(RB2_A),   m_a);
      check("data", 32'(RB2_D),   m_d);
      check("done", 32'(S2_done), 32'(m_done));
      if (!RB2_RW) strobes++;
    end
  end

  task automatic send(input int a, input int d, input int n, input int gap);
    int b;
    for (int i = 0; i < n; i++) begin
      if (i < 3)       b = (a >> (2 - i)) & 1;
      else if (i < 21) b = (d >> (20 - i)) & 1;
      else             b = int'($urandom_range(0, 1));
      sen = 1'b0; sd = b[0];
      @(negedge clk);
    end
    for (int i = 0; i < gap; i++) begin
      sen = 1'b1; sd = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic expect_write(input string name, input int a, input int d);
    bit found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      if (!RB2_RW) found = 1;
      else @(negedge clk);
    end
    check({name, "_strobe"}, 32'(found), 32'd1);
    if (found) begin
      check({name, "_a"}, 32'(RB2_A), a);
      check({name, "_d"}, 32'(RB2_D), d);
      @(negedge clk);
      check({name, "_rw_back"}, 32'(RB2_RW), 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s0, len, gap;
    logic [17:0] pat [4] = '{18'h3FFFF, 18'h00000, 18'h15555, 18'h2AAAA};
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_rw", 32'(RB2_RW), 32'd1);
    check("reset_a", 32'(RB2_A), 32'd0);
    check("reset_d", 32'(RB2_D), 32'd0);
    check("reset_done", 32'(S2_done), 32'd0);

    send(5, 'h2A5C3, 21, 1);
    expect_write("single", 5, 'h2A5C3);
    check("single_done", 32'(S2_done), 32'd0);

    s0 = strobes;
    send(7, 'h1FFFF, 10, 2);
    check("runt_no_write", 32'(strobes - s0), 32'd0);
    send(2, 'h00001, 21, 1);
    expect_write("after_runt", 2, 'h00001);

    send(1, 'h3F0F0, 25, 1);
    expect_write("overlong", 1, 'h3F0F0);

    send(4, 'h0AAAA, 12, 0);
    rst = 1'b1; sen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rw", 32'(RB2_RW), 32'd1);
    check("midrst_a", 32'(RB2_A), 32'd0);
    check("midrst_d", 32'(RB2_D), 32'd0);
    send(6, 'h12345, 21, 1);
    expect_write("after_rst", 6, 'h12345);

    do_reset();
    s0 = strobes;
    for (int f = 0; f < 8; f++)
      send(f, (f < 4) ? int'(pat[f]) : int'($urandom_range(0, 'h3FFFF)), 21, 1);
    for (int k = 0; k < 5 && !S2_done; k++) @(negedge clk);
    check("seq_done", 32'(S2_done), 32'd1);
    check("seq_strobes", 32'(strobes - s0), 32'd8);

    s0 = strobes;
    send(3, 'h11111, 21, 4);
    check("post_done_no_write", 32'(strobes - s0), 32'd0);
    check("post_done_flag", 32'(S2_done), 32'd1);

    do_reset();
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 5))
        0:       len = int'($urandom_range(1, 20));
        1:       len = int'($urandom_range(22, 26));
        default: len = 21;
      endcase
      gap = int'($urandom_range(1, 3));
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 'h3FFFF)), len, gap);
    end
    repeat (4) @(negedge clk);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/s2_deserializer.md
# s2_deserializer

Serial receiver at the far end of the S1 link. Samples the `sen`/`sd` serial frames that S1 emits on falling edges and reconstructs each frame's 3-bit packet address and 18-bit payload. Writes each completed word into register bank RB2 (8 entries × 18 bits), one write per frame. Raises a sticky done flag after eight frames have been stored.

## Interface
Parameters:
- `ADDR_BITS`, default 3: address field length, in bits, sent MSB first.
- `DATA_BITS`, default 18: payload length, in bits, sent MSB first.
- `N_FRAMES`, default 8: number of stored frames before done.

Ports:
- `clk`  input  1  system clock; all sampling and all state on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `sen`  input  1  serial enable, active-low; low for the whole frame.
- `sd`  input  1  serial data; valid at every rising edge while `sen`=0.
- `RB2_RW`  output  1  RB2 control: 1 = read/idle, 0 = write.
- `RB2_A`  output  3  RB2 write address.
- `RB2_D`  output  18  RB2 write data.
- `RB2_Q`  input  18  RB2 read port; unused, no functional effect.
- `S2_done`  output  1  high once `N_FRAMES` writes are complete; sticky until `rst`.

## Operation
- Frame format: `sen` goes low, then 21 bits arrive, one per cycle.
  - Bits 0–2: address, MSB first.
  - Bits 3–20: data, MSB first, so the first data bit received is `RB2_D[17]`.
  - `sen` then returns high for at least one cycle.
- Receive path:
  - 5-bit bit counter `bcnt` (0..21).
  - 3-bit address shift register and 18-bit data shift register.
  - Each rising edge with `sen`=0 and `bcnt`<3: shift `sd` into the address register; `bcnt`++.
  - Each rising edge with `sen`=0 and 3≤`bcnt`<21: shift `sd` into the data register; `bcnt`++.
  - `sen`=0 with `bcnt`=21: the bit is ignored; overlong frame, no overwrite.
- Frame close, on a rising edge with `sen`=1:
  - `bcnt`=21: copy the shift registers into the `RB2_A`/`RB2_D` holding registers and set `wr_pend`; `bcnt`←0.
  - `bcnt` in 1..20: runt frame; discard, no write; `bcnt`←0.
  - `bcnt`=0: idle; no action.
- Write: `RB2_RW` = ~`wr_pend`, registered, so the write strobe lasts exactly one cycle. The 3-bit frame counter `fcnt` increments in the strobe cycle.
- Capture and output registers are separate. A new frame whose first bit arrives during the write-strobe cycle is captured without corrupting `RB2_A`/`RB2_D`.
- FSM states:
  - IDLE: `sen`=1, `bcnt`=0.
  - ADDR: `bcnt`<3.
  - DATA: 3≤`bcnt`<21.
  - FULL: `bcnt`=21, waiting for `sen`=1.
  - DONE.
- Transitions:
  - IDLE→ADDR when `sen`=0.
  - ADDR→DATA after the third bit.
  - DATA→FULL after the 21st bit.
  - FULL→IDLE on `sen`=1, with the write issued.
  - ADDR/DATA→IDLE on `sen`=1 (runt).
  - →DONE when the `N_FRAMES`th write strobe completes.
- DONE:
  - `S2_done`=1 and `RB2_RW` held at 1.
  - All further frames are ignored; no further writes occur.
- Duplicate addresses each count as a frame; the last write wins in RB2.

## Timing
- Reset values: `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `S2_done`=0, `bcnt`=0, `fcnt`=0, state IDLE.
- Reset mid-frame or mid-strobe: everything returns to the reset values on that edge. A pending write is dropped.
- Latency:
  - Edge E samples `sen`=1 at `bcnt`=21.
  - `RB2_A`/`RB2_D` update and `RB2_RW`=0 for the cycle after E.
  - `RB2_RW` returns to 1 at E+2.
- `S2_done` rises at the same edge that ends the 8th strobe (E+2 of the 8th frame).
- Back-to-back frames with a single `sen`-high cycle between them (S1 cadence: 21 low, 1 high) are sustained with no lost bits.
- `RB2_A`/`RB2_D` stay stable from the strobe cycle until the next frame close.

## Test plan
- **Single frame.** Address 3'b101, data 18'h2A5C3, `sen` high afterwards → one cycle with `RB2_RW`=0, `RB2_A`=5, `RB2_D`=18'h2A5C3; `S2_done`=0.
- **Full S1 sequence.** Eight back-to-back frames, addresses 0..7, data 18'h3FFFF, 18'h00000, 18'h15555, …; one idle cycle between frames → eight one-cycle strobes with matching A/D; `S2_done`=1 after the 8th and stays 1.
- **Runt frame.** `sen` low for 10 bits, then high → no strobe, `fcnt` unchanged. A following valid frame (address 2, 18'h00001) writes correctly.
- **Overlong frame.** 25 bits: address 1, then 18'h3F0F0, then 4 extra bits → write with `RB2_A`=1, `RB2_D`=18'h3F0F0; extra bits ignored.
- **Reset mid-frame.** `rst` asserted after 12 bits → outputs at reset values next edge, no write. The next full frame (address 6, 18'h12345) writes normally.
- **Post-done.** After `S2_done`=1, send a 9th valid frame → `RB2_RW` stays 1, `RB2_A`/`RB2_D` unchanged, `S2_done` stays 1.
